// File: rtl/keypad_scanner_if.sv
// Pin-side bundle of the keypad scanner: matrix rows/columns plus the encoded-key strobe
// toward the code-lock decider.
interface keypad_scanner_if;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] Code_1;
    logic       Valid_1;
    logic       key_held;

    modport master (input col_n, output row_n, output Code_1, output Valid_1, output key_held);
    modport slave  (output col_n, input row_n, input Code_1, input Valid_1, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row scan, column synchronisation, press/release debounce and
// key encoding. Emits exactly one Valid_1 strobe per debounced press, no auto-repeat.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic             clk,
    input  logic             reset_1,
    keypad_scanner_if.master kp
);
    localparam int unsigned TMR_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam bit ACCEPT_ON_FIRST = (DEBOUNCE_CNT <= 1);

    typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [2:0]       col_s1, col_s2;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [3:0]       row_drv, row_drv_nxt;
    logic [2:0]       cand, cand_nxt;
    logic [CNT_W-1:0] stable_cnt, stable_nxt, stable_inc;
    logic [CNT_W-1:0] rel_cnt, rel_nxt, rel_inc;
    logic [3:0]       code, code_nxt;
    logic             valid, valid_nxt, held, held_nxt;
    logic             tick, single, cand_match, cand_high;
    logic             scan_hit, accept, drop, release_done, advance;

    function automatic logic [3:0] encode(input logic [1:0] r, input logic [2:0] pat);
        logic [3:0] c;
        case (pat)
            3'b110:  c = 4'd0;
            3'b101:  c = 4'd1;
            default: c = 4'd2;
        endcase
        if (r == 2'd3) begin
            case (c)
                4'd0:    return 4'd10;
                4'd1:    return 4'd0;
                default: return 4'd11;
            endcase
        end
        return {2'b00, r} * 4'd3 + c + 4'd1;
    endfunction

    // Sample decode and the events that steer both the FSM and the datapath
    assign tick         = (timer == TMR_W'(SCAN_DIV - 1));
    assign single       = (col_s2 == 3'b110) || (col_s2 == 3'b101) || (col_s2 == 3'b011);
    assign cand_match   = (col_s2 == cand);
    assign cand_high    = ((~col_s2 & ~cand) == 3'b000);
    assign stable_inc   = stable_cnt + CNT_W'(1);
    assign rel_inc      = rel_cnt + CNT_W'(1);
    assign scan_hit     = tick && (state == SCAN) && single;
    assign drop         = tick && (state == DEBOUNCE) && !cand_match;
    assign accept       = (scan_hit && ACCEPT_ON_FIRST) ||
                          (tick && (state == DEBOUNCE) && cand_match &&
                           (stable_inc >= CNT_W'(DEBOUNCE_CNT)));
    assign release_done = tick && (state == HOLD) && cand_high &&
                          (rel_inc >= CNT_W'(DEBOUNCE_CNT));
    assign advance      = (tick && (state == SCAN) && !single) || drop || release_done;

    always_ff @(posedge clk) begin
        if (reset_1) state <= SCAN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)                    state_nxt = HOLD;
        else if (scan_hit)             state_nxt = DEBOUNCE;
        else if (drop || release_done) state_nxt = SCAN;
    end

    always_comb begin
        timer_nxt   = tick ? '0 : timer + TMR_W'(1);
        row_idx_nxt = advance ? row_idx + 2'd1 : row_idx;
        row_drv_nxt = ~(4'b0001 << row_idx_nxt);
        cand_nxt    = scan_hit ? col_s2 : cand;
        stable_nxt  = stable_cnt;
        rel_nxt     = rel_cnt;
        code_nxt    = code;
        valid_nxt   = 1'b0;
        held_nxt    = held;
        if (tick) begin
            case (state)
                SCAN:     stable_nxt = scan_hit ? CNT_W'(1) : '0;
                DEBOUNCE: stable_nxt = cand_match ? stable_inc : '0;
                HOLD:     rel_nxt    = cand_high ? rel_inc : '0;
                default:  stable_nxt = '0;
            endcase
        end
        if (accept) begin
            code_nxt   = encode(row_idx, cand_nxt);
            valid_nxt  = 1'b1;
            held_nxt   = 1'b1;
            stable_nxt = '0;
            rel_nxt    = '0;
        end
        if (release_done) begin
            held_nxt = 1'b0;
            rel_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_1) begin
            col_s1     <= 3'b000;
            col_s2     <= 3'b000;
            timer      <= '0;
            row_idx    <= 2'd0;
            row_drv    <= 4'b1110;
            cand       <= 3'b000;
            stable_cnt <= '0;
            rel_cnt    <= '0;
            code       <= 4'b0000;
            valid      <= 1'b0;
            held       <= 1'b0;
        end else begin
            col_s1     <= kp.col_n;
            col_s2     <= col_s1;
            timer      <= timer_nxt;
            row_idx    <= row_idx_nxt;
            row_drv    <= row_drv_nxt;
            cand       <= cand_nxt;
            stable_cnt <= stable_nxt;
            rel_cnt    <= rel_nxt;
            code       <= code_nxt;
            valid      <= valid_nxt;
            held       <= held_nxt;
        end
    end

    assign kp.row_n    = row_drv;
    assign kp.Code_1   = code;
    assign kp.Valid_1  = valid;
    assign kp.key_held = held;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model plus a code scoreboard
// (expected codes queued at press, compared against each observed Valid_1 strobe).
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset_1 = 1'b1;
    logic [11:0] keys = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          double_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  obs_q[$];

    keypad_scanner_if bus();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .reset_1(reset_1), .kp(bus.master)
    );

    always #5 clk = ~clk;

    // Key index = row*3 + col; a pressed key pulls its column low while its row is driven
    assign bus.col_n[0] = ~|({keys[9],  keys[6], keys[3], keys[0]} & ~bus.row_n);
    assign bus.col_n[1] = ~|({keys[10], keys[7], keys[4], keys[1]} & ~bus.row_n);
    assign bus.col_n[2] = ~|({keys[11], keys[8], keys[5], keys[2]} & ~bus.row_n);

    always @(negedge clk) begin
        if (bus.Valid_1) obs_q.push_back(bus.Code_1);
        if (bus.Valid_1 && prev_valid) double_cnt <= double_cnt + 1;
        prev_valid <= bus.Valid_1;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        ok = (obs_q.size() >= n);
    endtask

    task automatic wait_held(input logic val, input int budget, output bit ok);
        int t = 0;
        while (bus.key_held !== val && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        ok = (bus.key_held === val);
    endtask

    task automatic test_reset();
        logic [3:0] seq[4];
        logic [3:0] prev;
        int idx = 0, cyc = 0, last = 0;
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
        reset_1 = 1'b1;
        cycles(2);
        vectors++;
        if (bus.row_n !== 4'b1110) begin miscompares++; $display("FAIL reset_row_n: got %b want 1110", bus.row_n); end
        vectors++;
        if (bus.Code_1 !== 4'b0000) begin miscompares++; $display("FAIL reset_code: got %b want 0000", bus.Code_1); end
        vectors++;
        if (bus.Valid_1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.Valid_1); end
        vectors++;
        if (bus.key_held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", bus.key_held); end
        reset_1 = 1'b0;
        prev = bus.row_n;
        while (idx < 4 && cyc < 30) begin
            cycles(1);
            cyc++;
            if (bus.row_n !== prev) begin
                vectors++;
                if (bus.row_n !== seq[idx]) begin
                    miscompares++;
                    $display("FAIL row_seq[%0d]: got %b want %b", idx, bus.row_n, seq[idx]);
                end
                vectors++;
                if (cyc - last != 4) begin
                    miscompares++;
                    $display("FAIL row_interval[%0d]: got %0d cycles want 4", idx, cyc - last);
                end
                last = cyc;
                prev = bus.row_n;
                idx++;
            end
        end
        vectors++;
        if (idx != 4) begin miscompares++; $display("FAIL row_seq_count: got %0d changes want 4", idx); end
    endtask

    task automatic test_single();
        bit ok;
        logic [3:0] got, want;
        exp_q.delete(); obs_q.delete();
        exp_q.push_back(4'b0101);
        keys[4] = 1'b1;
        cycles(200);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++; $display("FAIL single_pulses: got %0d want 1", obs_q.size());
        end else begin
            vectors++;
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin miscompares++; $display("FAIL single_code: got %b want %b", got, want); end
        end
        vectors++;
        if (bus.key_held !== 1'b1) begin miscompares++; $display("FAIL single_held: got %b want 1", bus.key_held); end
        keys[4] = 1'b0;
        cycles(6);
        vectors++;
        if (bus.key_held !== 1'b1) begin miscompares++; $display("FAIL single_held_early: got %b want 1", bus.key_held); end
        wait_held(1'b0, 20, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL single_release: key_held %b want 0 within budget", bus.key_held); end
        vectors++;
        if (bus.row_n !== 4'b1011) begin miscompares++; $display("FAIL single_resume_row: got %b want 1011", bus.row_n); end
        cycles(20);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL single_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_specials();
        int         idx_tab[3];
        logic [3:0] code_tab[3];
        bit         ok;
        logic [3:0] got, want;
        idx_tab[0] = 11; idx_tab[1] = 9;  idx_tab[2] = 10;
        code_tab[0] = 4'b1011; code_tab[1] = 4'b1010; code_tab[2] = 4'b0000;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(code_tab[k]);
            keys[idx_tab[k]] = 1'b1;
            wait_obs(1, 100, ok);
            vectors++;
            if (!ok) begin
                miscompares++; $display("FAIL special_pulse[%0d]: got 0 pulses want 1", k);
                void'(exp_q.pop_front());
            end else begin
                vectors++;
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin miscompares++; $display("FAIL special_code[%0d]: got %b want %b", k, got, want); end
            end
            cycles(20);
            keys[idx_tab[k]] = 1'b0;
            wait_held(1'b0, 60, ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL special_release[%0d]: key_held %b want 0", k, bus.key_held); end
            cycles(10);
        end
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL special_extra: got %0d extra pulses want 0", obs_q.size()); end
    endtask

    task automatic test_bounce();
        bit ok;
        int t = 0;
        logic [3:0] got, want;
        exp_q.delete(); obs_q.delete();
        while (bus.row_n === 4'b1011 && t < 40) begin cycles(1); t++; end
        while (bus.row_n !== 4'b1011 && t < 40) begin cycles(1); t++; end
        vectors++;
        if (bus.row_n !== 4'b1011) begin miscompares++; $display("FAIL bounce_align: row_n %b want 1011", bus.row_n); end
        keys[6] = 1'b1;
        cycles(9);
        keys[6] = 1'b0;
        cycles(3);
        vectors++;
        if (bus.row_n !== 4'b0111) begin miscompares++; $display("FAIL bounce_row_adv: got %b want 0111", bus.row_n); end
        vectors++;
        if (bus.key_held !== 1'b0) begin miscompares++; $display("FAIL bounce_held: got %b want 0", bus.key_held); end
        cycles(10);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL bounce_pulse: got %0d pulses want 0", obs_q.size()); end
        exp_q.push_back(4'b0111);
        keys[6] = 1'b1;
        wait_obs(1, 100, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL bounce_steady_pulse: got 0 pulses want 1");
        end else begin
            vectors++;
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin miscompares++; $display("FAIL bounce_code: got %b want %b", got, want); end
        end
        cycles(20);
        keys[6] = 1'b0;
        wait_held(1'b0, 60, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bounce_release: key_held %b want 0", bus.key_held); end
        cycles(10);
    endtask

    task automatic test_ghost();
        bit ok;
        logic [3:0] got, want;
        exp_q.delete(); obs_q.delete();
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        cycles(100);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL ghost_pulse: got %0d pulses want 0", obs_q.size()); end
        exp_q.push_back(4'b0001);
        keys[1] = 1'b0;
        wait_obs(1, 100, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL ghost_single_pulse: got 0 pulses want 1");
        end else begin
            vectors++;
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin miscompares++; $display("FAIL ghost_code: got %b want %b", got, want); end
        end
        cycles(20);
        keys[0] = 1'b0;
        wait_held(1'b0, 60, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ghost_release: key_held %b want 0", bus.key_held); end
        cycles(10);
    endtask

    task automatic test_reset_in_hold();
        bit ok;
        logic [3:0] got, want;
        exp_q.delete(); obs_q.delete();
        exp_q.push_back(4'b1001);
        keys[8] = 1'b1;
        wait_obs(1, 100, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL hold9_pulse: got 0 pulses want 1");
            void'(exp_q.pop_front());
        end else begin
            vectors++;
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin miscompares++; $display("FAIL hold9_code: got %b want %b", got, want); end
        end
        cycles(5);
        vectors++;
        if (bus.key_held !== 1'b1) begin miscompares++; $display("FAIL hold9_held: got %b want 1", bus.key_held); end
        reset_1 = 1'b1;
        cycles(2);
        vectors++;
        if (bus.row_n !== 4'b1110) begin miscompares++; $display("FAIL hold9_rst_row: got %b want 1110", bus.row_n); end
        vectors++;
        if (bus.Code_1 !== 4'b0000) begin miscompares++; $display("FAIL hold9_rst_code: got %b want 0000", bus.Code_1); end
        vectors++;
        if (bus.Valid_1 !== 1'b0) begin miscompares++; $display("FAIL hold9_rst_valid: got %b want 0", bus.Valid_1); end
        vectors++;
        if (bus.key_held !== 1'b0) begin miscompares++; $display("FAIL hold9_rst_held: got %b want 0", bus.key_held); end
        reset_1 = 1'b0;
        exp_q.push_back(4'b1001);
        wait_obs(1, 100, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL hold9_redetect: got 0 pulses want 1");
        end else begin
            vectors++;
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin miscompares++; $display("FAIL hold9_redetect_code: got %b want %b", got, want); end
        end
        cycles(30);
        vectors++;
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL hold9_extra: got %0d extra pulses want 0", obs_q.size()); end
        keys[8] = 1'b0;
        wait_held(1'b0, 60, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL hold9_release: key_held %b want 0", bus.key_held); end
    endtask

    task automatic test_no_double();
        vectors++;
        if (double_cnt != 0) begin miscompares++; $display("FAIL valid_back_to_back: got %0d want 0", double_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_specials();
        test_bounce();
        test_ghost();
        test_reset_in_hold();
        test_no_double();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
